// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   - operation encodings seen on op_sel
//   - sequencer state encodings
//   - default abort timeout and timer width
//   - skips_unit(): tells whether an accepted operation retires without
//     starting the multiplier or the divider
package cpu_defs_pkg;

  localparam int DATA_W      = 32;
  localparam int TIMEOUT_DEF = 40;
  localparam int TIMER_W     = 6;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // A multiply by zero has a known result, a divide by zero is an exception,
  // and moves to HI/LO need no arithmetic: none of these start a unit.
  function automatic logic skips_unit(input op_e op,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
    case (op)
      OP_MULT: return (a == '0) || (b == '0);
      OP_DIV:  return (b == '0);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/op_timer.sv
// Abort timer for the WAIT state of mult_div_ctrl.
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_clear   zero the count (held in ISSUE)
//   i_enable  count this cycle (held in WAIT)
//   o_expired high in the enabled cycle whose increment reaches TIMEOUT,
//             i.e. the TIMEOUT-th WAIT cycle
module op_timer
  import cpu_defs_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = TIMER_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer between the control unit and the external multiplier/divider.
// Owns the architectural HI/LO registers.
// Ports:
//   i_clk, i_rst_n                clock, asynchronous active-low reset
//   i_op_valid, i_op_sel          request and operation (MULT/DIV/MTHI/MTLO)
//   i_op_a, i_op_b                operands (rs, rt); MTHI/MTLO use i_op_a only
//   o_op_ready                    high in IDLE; accept = i_op_valid & o_op_ready
//   o_busy                        stall, high outside IDLE
//   o_mult_start, o_div_start     one-cycle unit start pulses
//   o_unit_a, o_unit_b            latched operands presented to both units
//   i_mult_done/_hi/_lo           multiplier completion and product
//   i_div_done/_quot/_rem         divider completion and result
//   o_hi, o_lo                    HI/LO registers
//   o_done                        one-cycle retire pulse (written or aborted)
//   o_div_zero                    one-cycle divide-by-zero pulse, with o_done
//   o_err                         one-cycle timeout-abort pulse, with o_done
module mult_div_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = TIMER_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_valid,
  input  logic [1:0]  i_op_sel,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic        o_op_ready,
  output logic        o_busy,
  output logic        o_mult_start,
  output logic        o_div_start,
  output logic [31:0] o_unit_a,
  output logic [31:0] o_unit_b,
  input  logic        i_mult_done,
  input  logic [31:0] i_mult_hi,
  input  logic [31:0] i_mult_lo,
  input  logic        i_div_done,
  input  logic [31:0] i_div_quot,
  input  logic [31:0] i_div_rem,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_done,
  output logic        o_div_zero,
  output logic        o_err
);

  state_e             r_state;
  op_e                r_op_sel;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;
  logic               r_mult_start;
  logic               r_div_start;
  logic               r_done;
  logic               r_div_zero;
  logic               r_err;

  op_e                w_op_in;
  logic               w_accept;
  logic               w_unit_done;
  logic               w_tmr_clear;
  logic               w_tmr_en;
  logic               w_expired;

  assign w_op_in  = op_e'(i_op_sel);
  assign w_accept = i_op_valid && (r_state == ST_IDLE);

  // Only the unit that was started is listened to; the other one's done is
  // meaningless for this operation.
  assign w_unit_done = (r_op_sel == OP_MULT) ? i_mult_done : i_div_done;

  assign w_tmr_clear = (r_state == ST_ISSUE);
  assign w_tmr_en    = (r_state == ST_WAIT);

  op_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_op_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );

  // Operand latch: data only, loaded on accept and then held stable on the
  // unit operand outputs until the next accept.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_op_a <= i_op_a;
      r_op_b <= i_op_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_op_sel     <= OP_MULT;
      r_hi         <= '0;
      r_lo         <= '0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_done       <= 1'b0;
      r_div_zero   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_done       <= 1'b0;
      r_div_zero   <= 1'b0;
      r_err        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_op_valid) begin
            r_op_sel <= w_op_in;
            if (skips_unit(w_op_in, i_op_a, i_op_b)) begin
              // Retire next cycle; HI/LO written now so WRITE shows them.
              r_state <= ST_WRITE;
              r_done  <= 1'b1;
              case (w_op_in)
                OP_MTHI: r_hi <= i_op_a;
                OP_MTLO: r_lo <= i_op_a;
                OP_MULT: begin
                  r_hi <= '0;
                  r_lo <= '0;
                end
                OP_DIV:  r_div_zero <= 1'b1;
              endcase
            end else begin
              r_state      <= ST_ISSUE;
              r_mult_start <= (w_op_in == OP_MULT);
              r_div_start  <= (w_op_in == OP_DIV);
            end
          end
        end

        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A done in the expiry cycle still wins over the abort.
          if (w_unit_done) begin
            r_state <= ST_WRITE;
            r_done  <= 1'b1;
            if (r_op_sel == OP_MULT) begin
              r_hi <= i_mult_hi;
              r_lo <= i_mult_lo;
            end else begin
              r_hi <= i_div_rem;
              r_lo <= i_div_quot;
            end
          end else if (w_expired) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end

        ST_WRITE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_op_ready   = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_mult_start = r_mult_start;
  assign o_div_start  = r_div_start;
  assign o_unit_a     = r_op_a;
  assign o_unit_b     = r_op_b;
  assign o_hi         = r_hi;
  assign o_lo         = r_lo;
  assign o_done       = r_done;
  assign o_div_zero   = r_div_zero;
  assign o_err        = r_err;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl with behavioural multiplier/divider
// models and a queue of expected retirements.
module tb_mult_div_ctrl;

  localparam logic [1:0] OPC_MULT = 2'b00;
  localparam logic [1:0] OPC_DIV  = 2'b01;
  localparam logic [1:0] OPC_MTHI = 2'b10;
  localparam logic [1:0] OPC_MTLO = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [1:0]  op_sel;
  logic [31:0] op_a, op_b;
  logic        op_ready, busy, mult_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic        mult_done, div_done;
  logic [31:0] mult_hi, mult_lo, div_quot, div_rem;
  logic [31:0] hi, lo;
  logic        done, div_zero, err;

  // unit models
  logic        m_bfm_done, m_spur, d_bfm_done, d_spur;
  logic [31:0] m_bfm_hi, m_bfm_lo, d_bfm_q, d_bfm_r;
  int          mult_lat = -1;
  int          div_lat  = -1;
  logic [63:0] mult_res;
  logic [31:0] div_q_res, div_r_res;

  assign mult_done = m_bfm_done | m_spur;
  assign mult_hi   = m_spur ? 32'hBADBAD01 : m_bfm_hi;
  assign mult_lo   = m_spur ? 32'hBADBAD02 : m_bfm_lo;
  assign div_done  = d_bfm_done | d_spur;
  assign div_quot  = d_spur ? 32'hBADBAD03 : d_bfm_q;
  assign div_rem   = d_spur ? 32'hBADBAD04 : d_bfm_r;

  mult_div_ctrl #(.TIMEOUT(40), .CW(6)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_op_valid   (op_valid),
    .i_op_sel     (op_sel),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
    .o_op_ready   (op_ready),
    .o_busy       (busy),
    .o_mult_start (mult_start),
    .o_div_start  (div_start),
    .o_unit_a     (unit_a),
    .o_unit_b     (unit_b),
    .i_mult_done  (mult_done),
    .i_mult_hi    (mult_hi),
    .i_mult_lo    (mult_lo),
    .i_div_done   (div_done),
    .i_div_quot   (div_quot),
    .i_div_rem    (div_rem),
    .o_hi         (hi),
    .o_lo         (lo),
    .o_done       (done),
    .o_div_zero   (div_zero),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_done = 0, n_mstart = 0, n_dstart = 0;
  always @(negedge clk) begin
    if (done)       n_done   <= n_done + 1;
    if (mult_start) n_mstart <= n_mstart + 1;
    if (div_start)  n_dstart <= n_dstart + 1;
  end

  // Unit latency = idle cycles between the start cycle and the done cycle.
  initial begin
    m_bfm_done = 0; m_bfm_hi = 0; m_bfm_lo = 0;
    forever begin
      @(negedge clk);
      if (mult_start && mult_lat >= 0) begin
        repeat (mult_lat + 1) @(posedge clk);
        #1 m_bfm_done = 1; {m_bfm_hi, m_bfm_lo} = mult_res;
        @(posedge clk);
        #1 m_bfm_done = 0;
      end
    end
  end

  initial begin
    d_bfm_done = 0; d_bfm_q = 0; d_bfm_r = 0;
    forever begin
      @(negedge clk);
      if (div_start && div_lat >= 0) begin
        repeat (div_lat + 1) @(posedge clk);
        #1 d_bfm_done = 1; d_bfm_q = div_q_res; d_bfm_r = div_r_res;
        @(posedge clk);
        #1 d_bfm_done = 0;
      end
    end
  end

  // scoreboard
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    logic        dz;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l,
                          input logic e, input logic z, input int lat);
    exp_t x;
    x.hi = h; x.lo = l; x.err = e; x.dz = z; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic set_mult(input int a, input int b);
    longint p;
    p = a;
    p = p * b;
    mult_res = p;
  endtask

  task automatic set_div(input int a, input int b);
    div_q_res = a / b;
    div_r_res = a % b;
  endtask

  task automatic do_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!op_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_op", op_ready, 1);
    op_valid = 1; op_sel = sel; op_a = a; op_b = b;
    acc_cyc = cyc;
    @(posedge clk); #1 op_valid = 0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    bit   gap, seen;
    n = 0; gap = 0; seen = 0;
    while (n < 300) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) gap = 1;
      n++;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_busy_until_retire"}, gap, 0);
      check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_lo"}, lo, e.lo);
        check({tag, "_err"}, err, e.err);
        check({tag, "_div_zero"}, div_zero, e.dz);
        check({tag, "_latency"}, cyc - acc_cyc, e.lat);
      end
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
    end
  endtask

  initial begin
    int m0, d0, dn0;
    rst_n = 0; op_valid = 0; op_sel = 0; op_a = 0; op_b = 0;
    m_spur = 0; d_spur = 0; mult_res = 0; div_q_res = 0; div_r_res = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mstart", mult_start, 0);
    check("rst_dstart", div_start, 0);
    rst_n = 1;

    // MULT 7 x -3, multiplier latency 34
    mult_lat = 34; set_mult(7, -3);
    m0 = n_mstart;
    push_exp(32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 37);
    do_op(OPC_MULT, 32'd7, 32'hFFFFFFFD);
    wait_done("mult_7x-3");
    check("mult_one_start", n_mstart, m0 + 1);
    check("unit_a_held", unit_a, 32'd7);
    check("unit_b_held", unit_b, 32'hFFFFFFFD);

    // DIV 100 / 7
    div_lat = 5; set_div(100, 7);
    push_exp(32'd2, 32'd14, 0, 0, 8);
    do_op(OPC_DIV, 32'd100, 32'd7);
    wait_done("div_100_7");

    // DIV 5 / 0: exception, HI/LO untouched, no divider start
    d0 = n_dstart;
    push_exp(32'd2, 32'd14, 0, 1, 1);
    do_op(OPC_DIV, 32'd5, 32'd0);
    wait_done("div_by_zero");
    check("div0_no_start", n_dstart, d0);

    // MULT 0 x 12345: immediate zero result, no multiplier start
    m0 = n_mstart;
    push_exp(32'd0, 32'd0, 0, 0, 1);
    do_op(OPC_MULT, 32'd0, 32'd12345);
    wait_done("mult_zero");
    check("mult0_no_start", n_mstart, m0);

    // MULT 3 x 5 with a stray divider done during WAIT
    mult_lat = 6; set_mult(3, 5);
    push_exp(32'd0, 32'd15, 0, 0, 9);
    do_op(OPC_MULT, 32'd3, 32'd5);
    @(posedge clk); #1 d_spur = 1;
    @(posedge clk); #1 d_spur = 0;
    wait_done("mult_ignore_div_done");

    // stray multiplier done in IDLE
    dn0 = n_done;
    @(posedge clk); #1 m_spur = 1;
    @(posedge clk); #1 m_spur = 0;
    repeat (3) @(negedge clk);
    check("idle_done_no_retire", n_done, dn0);
    check("idle_done_hi", hi, 0);
    check("idle_done_lo", lo, 15);

    // done in the 40th WAIT cycle wins over timeout
    mult_lat = 39; set_mult(2, 3);
    push_exp(32'd0, 32'd6, 0, 0, 42);
    do_op(OPC_MULT, 32'd2, 32'd3);
    wait_done("mult_done_at_timeout");

    // no done at all: abort after 40 WAIT cycles
    mult_lat = -1;
    push_exp(32'd0, 32'd6, 1, 0, 42);
    do_op(OPC_MULT, 32'd4, 32'd4);
    wait_done("mult_timeout");
    check("timeout_ready_back", op_ready, 1);
    check("timeout_busy_low", busy, 0);

    // done one cycle too late: abort, late done ignored
    mult_lat = 40; set_mult(5, 5);
    push_exp(32'd0, 32'd6, 1, 0, 42);
    do_op(OPC_MULT, 32'd5, 32'd5);
    wait_done("mult_late_done");
    repeat (2) @(negedge clk);
    check("late_done_hi", hi, 0);
    check("late_done_lo", lo, 6);

    // MTHI then MTLO with op_valid held throughout
    @(posedge clk); #1;
    op_valid = 1; op_sel = OPC_MTHI; op_a = 32'hDEADBEEF; op_b = 32'd0;
    acc_cyc = cyc;
    push_exp(32'hDEADBEEF, 32'd6, 0, 0, 1);
    @(posedge clk); #1;
    op_sel = OPC_MTLO; op_a = 32'h12345678;
    check("b2b_not_ready_in_write", op_ready, 0);
    wait_done("mthi");
    check("b2b_lo_not_early", lo, 6);
    check("b2b_ready_after_done", op_ready, 1);
    acc_cyc = cyc;
    push_exp(32'hDEADBEEF, 32'h12345678, 0, 0, 1);
    @(posedge clk); #1 op_valid = 0;
    wait_done("mtlo");

    // signed DIV -100 / 7
    div_lat = 3; set_div(-100, 7);
    push_exp(32'hFFFFFFFE, 32'hFFFFFFF2, 0, 0, 6);
    do_op(OPC_DIV, 32'hFFFFFF9C, 32'd7);
    wait_done("div_neg");

    // reset 10 cycles into MULT WAIT, multiplier done arrives afterwards
    mult_lat = 20; set_mult(9, 9);
    do_op(OPC_MULT, 32'd9, 32'd9);
    repeat (11) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_ready", op_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    dn0 = n_done;
    repeat (15) @(negedge clk);
    check("postrst_no_done", n_done, dn0);
    check("postrst_hi", hi, 0);
    check("postrst_lo", lo, 0);
    check("postrst_ready", op_ready, 1);
    check("postrst_busy", busy, 0);
    check("postrst_sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, max cycles waited for a unit's done before abort.
REQ-002 SHALL have parameter CW, default 6, width of the timeout counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  control unit requests an operation this cycle.
REQ-006 op_sel  input  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-007 op_a  input  32  operand A (rs); sole source for MTHI/MTLO.
REQ-008 op_b  input  32  operand B (rt).
REQ-009 op_ready  output  1  high only in IDLE; request accepted when op_valid&&op_ready.
REQ-010 busy  output  1  stall to control unit; high in every state except IDLE.
REQ-011 mult_start  output  1  one-cycle start pulse to shared Booth multiplier.
REQ-012 mult_done, mult_hi, mult_lo  input  1/32/32  multiplier completion and result.
REQ-013 div_start  output  1  one-cycle start pulse to divider.
REQ-014 div_done, div_quot, div_rem  input  1/32/32  divider completion and result.
REQ-015 hi, lo  output  32 each  architectural HI/LO registers.
REQ-016 done  output  1  one-cycle pulse when an operation retires (written or aborted).
REQ-017 div_zero  output  1  one-cycle exception pulse, DIV with op_b==0.
REQ-018 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT, WRITE.
REQ-020 IDLE: on accept, op_a/op_b/op_sel SHALL be latched; next state per REQ-021..024; otherwise stay.
REQ-021 MTHI/MTLO SHALL go to WRITE, hi (or lo) <= latched op_a; no unit started; done one cycle after accept.
REQ-022 MULT with op_a==0 or op_b==0 SHALL go to WRITE with hi=lo=0; multiplier not started.
REQ-023 DIV with op_b==0 SHALL go to WRITE, pulse div_zero with done, leave hi/lo unchanged; divider not started.
REQ-024 Otherwise SHALL go to ISSUE.
REQ-025 ISSUE: exactly one cycle; mult_start or div_start high per latched op; latched operands held stable on unit operand outputs until WRITE; counter cleared; next WAIT.
REQ-026 WAIT: the selected unit's done SHALL be sampled; non-selected unit's done SHALL be ignored.
REQ-027 On done in WAIT: MULT captures hi<=mult_hi, lo<=mult_lo; DIV captures hi<=div_rem, lo<=div_quot; next WRITE.
REQ-028 Counter increments each WAIT cycle; on reaching TIMEOUT without done: err and done pulse, hi/lo unchanged, next IDLE.
REQ-029 done arriving in the same cycle the counter hits TIMEOUT SHALL win (result written, no err).
REQ-030 WRITE: done pulses; hi/lo updated in the transition into WRITE are visible this cycle; next IDLE.
REQ-031 op_valid while busy SHALL be ignored; no queuing.
REQ-032 Accept-to-done latency: 1 cycle for REQ-021..023; unit latency + 3 cycles otherwise.
REQ-033 Unit done outside WAIT SHALL have no effect.

Reset
REQ-034 Reset assertion at any time, including mid-WAIT, SHALL force IDLE, hi=lo=0, counter=0, all pulses and starts 0, op_ready=1, busy=0.
REQ-035 An operation interrupted by reset SHALL NOT write hi/lo after reset release, even if a late unit done arrives.

Structure
REQ-036 Op encodings, state encodings and TIMEOUT default SHALL live in shared package cpu_defs_pkg.
REQ-037 Timeout counter SHALL be sub-module op_timer (clear, enable, expired); multiplier and divider SHALL remain external instances.

Verification
REQ-038 MULT 7 x -3, multiplier done after 34 cycles -> hi=FFFFFFFF, lo=FFFFFFEB, one done pulse, busy high until WRITE.
REQ-039 DIV 100 / 7 -> lo=14, hi=2; DIV 5 / 0 -> div_zero+done one cycle after accept, hi/lo unchanged, div_start never high.
REQ-040 MULT 0 x 12345 -> hi=lo=0 one cycle after accept, mult_start never high.
REQ-041 MULT with mult_done held low, TIMEOUT=40 -> err+done pulse after 40 WAIT cycles, hi/lo unchanged, op_ready returns.
REQ-042 MTHI 0xDEADBEEF then MTLO 0x12345678 back-to-back with op_valid held -> second accepted only after first's done; final hi=DEADBEEF, lo=12345678.
REQ-043 Reset asserted 10 cycles into MULT WAIT, then mult_done pulsed after release -> hi=lo=0, no done, IDLE.
